// File: rtl/alu_pkg.sv
// alu_pkg: shared ALUControl codes and execute-unit state type
package alu_pkg;
   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;
   localparam logic [3:0] ALU_LSL   = 4'b1000;
   localparam logic [3:0] ALU_LSR   = 4'b1001;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational LEGv8 ALU; unknown codes yield zero
module alu import alu_pkg::*; #(
   parameter int N = 64
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   ALUControl,
   output logic [N-1:0] result,
   output logic         zero
);
   always_comb begin
      result = '0;
      case (ALUControl)
         ALU_AND:   result = a & b;
         ALU_OR:    result = a | b;
         ALU_ADD:   result = a + b;
         ALU_SUB:   result = a - b;
         ALU_PASSB: result = b;
         ALU_LSL:   result = a << b;
         ALU_LSR:   result = a >> b;
         default:   result = '0;
      endcase
   end
   assign zero = (result == '0);
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: start/done execute unit; shifts iterate one bit per cycle,
// everything else completes through the combinational alu in one cycle
module alu_multicycle import alu_pkg::*; #(
   parameter int N   = 64,
   parameter int SHW = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   ALUControl,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         zero
);
   alu_state_t state, state_n;
   logic [3:0]     op;
   logic [N-1:0]   acc, acc_sh, alu_res;
   logic [SHW-1:0] cnt;
   logic           alu_zero_unused, is_shift, big, count0, long_op, take;
   alu #(.N(N)) u_alu (.a(a), .b(b), .ALUControl(ALUControl), .result(alu_res), .zero(alu_zero_unused));
   assign is_shift = (ALUControl == ALU_LSL) || (ALUControl == ALU_LSR);
   assign big      = |b[N-1:SHW];
   assign count0   = (b[SHW-1:0] == '0);
   assign long_op  = is_shift && !big && !count0;
   assign take     = (state == IDLE) && start;
   assign acc_sh   = (op == ALU_LSL) ? acc << 1 : acc >> 1;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = start ? (long_op ? SHIFT : DONE) : IDLE;
         SHIFT:   state_n = (cnt == SHW'(1)) ? DONE : SHIFT;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         op     <= '0;
         acc    <= '0;
         cnt    <= '0;
         result <= '0;
      end else begin
         state <= state_n;
         if (take) begin
            op  <= ALUControl;
            acc <= a;
            cnt <= b[SHW-1:0];
            if (!long_op) result <= is_shift ? (big ? '0 : a) : alu_res;
         end else if (state == SHIFT) begin
            acc <= acc_sh;
            cnt <= cnt - SHW'(1);
            if (cnt == SHW'(1)) result <= acc_sh;
         end
      end
   end
   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign zero = (result == '0);
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: scoreboard bench for the multicycle execute unit
module tb_alu_multicycle;
   import alu_pkg::*;
   logic        clk = 0, reset = 1, start = 0;
   logic [63:0] a = 0, b = 0, result;
   logic [3:0]  ctl = 0;
   logic        busy, done, zero;
   int          total = 0, bad = 0;
   logic [63:0] exp_q[$];

   alu_multicycle #(.N(64), .SHW(6)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ALUControl(ctl),
      .busy(busy), .done(done), .result(result), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (done) begin
         if (exp_q.size() == 0) check("unexpected_done", 64'(done), 64'd0);
         else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            check("result", result, e);
            check("zero", 64'(zero), 64'(e == 0));
         end
      end
   end

   task automatic wait_done(input int lat, input string tag);
      int n = 1;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(n), 64'(lat));
   endtask

   task automatic do_op(input logic [63:0] xa, input logic [63:0] xb, input logic [3:0] c,
                        input logic [63:0] e, input int lat);
      @(negedge clk);
      a = xa; b = xb; ctl = c; start = 1;
      exp_q.push_back(e);
      @(negedge clk);
      start = 0;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; ctl = 4'($urandom);
      check("busy", 64'(busy), 64'd1);
      wait_done(lat, "latency");
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset = 0;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_zero", 64'(zero), 64'd1);

      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD,   64'd0, 1);
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_SUB,   64'hFFFF_FFFF_FFFF_FFFE, 1);
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_PASSB, 64'd1, 1);
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_AND,   64'd1, 1);
      do_op(64'h0000_0000_0000_00F0, 64'h0F, ALU_OR,   64'hFF, 1);
      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFE, 1);
      do_op(64'h1234, 64'h5678, 4'b0011, 64'd0, 1);
      do_op(64'hFFFF, 64'd16, ALU_LSL, 64'hFFFF_0000, 17);
      do_op(64'h8000_0000_0000_0000, 64'd63, ALU_LSR, 64'd1, 64);
      do_op(64'hFFFE, 64'd63, ALU_LSL, 64'd0, 64);
      do_op(64'hFFFF, 64'd0, ALU_LSL, 64'hFFFF, 1);
      do_op(64'hFFFF, 64'd64, ALU_LSL, 64'd0, 1);
      do_op(64'h1234_5678_9ABC_DEF0, 64'd4, ALU_LSR, 64'h0123_4567_89AB_CDEF, 5);

      // an ADD pulsed mid-shift must be dropped
      @(negedge clk);
      a = 64'hFFFF; b = 64'd16; ctl = ALU_LSL; start = 1;
      exp_q.push_back(64'hFFFF_0000);
      @(negedge clk);
      start = 0;
      repeat (3) @(negedge clk);
      a = 64'd1; b = 64'd2; ctl = ALU_ADD; start = 1;
      @(negedge clk);
      start = 0;
      wait_done(13, "busy_latency");
      repeat (4) @(negedge clk);
      check("busy_idle", 64'(busy), 64'd0);
      do_op(64'd1, 64'd2, ALU_ADD, 64'd3, 1);

      // reset during a long shift drops the pending done
      @(negedge clk);
      a = 64'hDEAD_BEEF_0000_0000; b = 64'd40; ctl = ALU_LSR; start = 1;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_result", result, 64'd0);
      check("mid_rst_zero", 64'(zero), 64'd1);
      repeat (45) @(negedge clk);
      do_op(64'hF0, 64'd4, ALU_LSR, 64'hF, 5);

      repeat (3) @(negedge clk);
      check("pending", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
